// File: rtl/rbm_pkg.sv
// Shared defaults, state encoding and address-width helper for the RBM inference sequencer.
package rbm_pkg;

  localparam int N_VISIBLE_DEFAULT = 784;
  localparam int N_HIDDEN_DEFAULT  = 441;
  localparam int N_CLASS_DEFAULT   = 10;
  localparam int W_WIDTH_DEFAULT   = 12;
  localparam int CNT_W_DEFAULT     = 8;

  typedef enum logic [3:0] {
    S_IDLE,
    S_H_TERM,
    S_H_BIAS,
    S_H_SAMPLE,
    S_C_TERM,
    S_C_BIAS,
    S_C_SAMPLE,
    S_ARGMAX,
    S_DONE
  } rbm_state_t;

  // Index width for a table of n entries; never narrower than one bit.
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rbm_sequencer_spike_counter_bank.sv
// Per-class saturating spike counters with a debug read port and a one-entry-per-cycle argmax scan.
module spike_counter_bank
  import rbm_pkg::*;
#(
  parameter int N_CLASS = N_CLASS_DEFAULT,
  parameter int CNT_W   = CNT_W_DEFAULT,
  localparam int IDX_W  = addr_w(N_CLASS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc_en,
  input  logic [IDX_W-1:0] inc_idx,
  input  logic             inc_val,
  input  logic             scan_en,
  input  logic [IDX_W-1:0] scan_idx,
  input  logic [IDX_W-1:0] rd_sel,
  output logic [CNT_W-1:0] rd_data,
  output logic [IDX_W-1:0] best_idx
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] count [N_CLASS];
  logic [CNT_W-1:0] best_val;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      for (int i = 0; i < N_CLASS; i++) count[i] <= '0;
      best_val <= '0;
      best_idx <= '0;
    end else begin
      if (inc_en && inc_val) begin
        for (int i = 0; i < N_CLASS; i++) begin
          if (inc_idx == IDX_W'(i) && count[i] != CNT_MAX) count[i] <= count[i] + 1'b1;
        end
      end
      // Entry 0 seeds the scan; strict compare keeps the lowest index on ties.
      if (scan_en) begin
        for (int i = 0; i < N_CLASS; i++) begin
          if (scan_idx == IDX_W'(i) && (i == 0 || count[i] > best_val)) begin
            best_val <= count[i];
            best_idx <= IDX_W'(i);
          end
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < N_CLASS; i++) begin
      if (rd_sel == IDX_W'(i)) rd_data = count[i];
    end
  end

endmodule

// File: rtl/rbm_sequencer.sv
// Sequences the Main RBM datapath through hidden and classifier layers for a programmable
// number of iterations, then reports the class with the most spikes.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | waiting for start
// S_H_TERM   | feed image_bit / hidden weight for pix_addr of hidden unit
// S_H_BIAS   | feed hidden bias with pixel forced to 1
// S_H_SAMPLE | bias again; latch Main's hidden bit into the buffer
// S_C_TERM   | feed buffered hidden bit / class weight for hid_addr
// S_C_BIAS   | feed class bias with hidden_pixel forced to 1
// S_C_SAMPLE | bias again; add Main's spike to the class counter
// S_ARGMAX   | scan one counter per cycle for the maximum
// S_DONE     | publish result, pulse done next cycle
module rbm_sequencer
  import rbm_pkg::*;
#(
  parameter int N_VISIBLE = N_VISIBLE_DEFAULT,
  parameter int N_HIDDEN  = N_HIDDEN_DEFAULT,
  parameter int N_CLASS   = N_CLASS_DEFAULT,
  parameter int W_WIDTH   = W_WIDTH_DEFAULT,
  parameter int CNT_W     = CNT_W_DEFAULT,
  localparam int PIX_W    = addr_w(N_VISIBLE),
  localparam int HID_W    = addr_w(N_HIDDEN),
  localparam int CLS_W    = addr_w(N_CLASS)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [7:0]         iterations,
  output logic               busy,
  output logic               done,
  output logic [CLS_W-1:0]   result_class,
  output logic [PIX_W-1:0]   pix_addr,
  output logic [HID_W-1:0]   hid_addr,
  output logic [CLS_W-1:0]   cls_addr,
  input  logic               image_bit,
  input  logic [W_WIDTH-1:0] h_weight,
  input  logic [W_WIDTH-1:0] h_bias,
  input  logic               order_bit,
  input  logic [W_WIDTH-1:0] c_weight,
  input  logic [W_WIDTH-1:0] c_bias,
  output logic [W_WIDTH-1:0] hvalue,
  output logic               pixel,
  output logic               hidden_switch,
  output logic               enable_hidden,
  output logic [W_WIDTH-1:0] cvalue,
  output logic               hidden_pixel,
  output logic               enable_classi,
  input  logic               hidden,
  input  logic               spike,
  input  logic [CLS_W-1:0]   cnt_sel,
  output logic [CNT_W-1:0]   cnt_out
);

  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(N_VISIBLE - 1);
  localparam logic [HID_W-1:0] HID_LAST = HID_W'(N_HIDDEN - 1);
  localparam logic [CLS_W-1:0] CLS_LAST = CLS_W'(N_CLASS - 1);

  rbm_state_t          state;
  logic [7:0]          iter_left;
  logic [N_HIDDEN-1:0] hbuf;
  logic [CLS_W-1:0]    best_idx;
  logic                accept;

  assign accept = (state == S_IDLE) && start;

  spike_counter_bank #(
    .N_CLASS (N_CLASS),
    .CNT_W   (CNT_W)
  ) u_counters (
    .clock    (clock),
    .reset    (reset),
    .clear    (accept),
    .inc_en   (state == S_C_SAMPLE),
    .inc_idx  (cls_addr),
    .inc_val  (spike),
    .scan_en  (state == S_ARGMAX),
    .scan_idx (cls_addr),
    .rd_sel   (cnt_sel),
    .rd_data  (cnt_out),
    .best_idx (best_idx)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= S_IDLE;
      iter_left     <= '0;
      hbuf          <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      result_class  <= '0;
      pix_addr      <= '0;
      hid_addr      <= '0;
      cls_addr      <= '0;
      enable_hidden <= 1'b0;
      enable_classi <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            busy      <= 1'b1;
            iter_left <= iterations;
            pix_addr  <= '0;
            hid_addr  <= '0;
            cls_addr  <= '0;
            if (iterations == 8'd0) begin
              state <= S_DONE;
            end else begin
              state         <= S_H_TERM;
              enable_hidden <= 1'b1;
            end
          end
        end
        S_H_TERM: begin
          if (pix_addr == PIX_LAST) state <= S_H_BIAS;
          else pix_addr <= pix_addr + 1'b1;
        end
        S_H_BIAS: state <= S_H_SAMPLE;
        S_H_SAMPLE: begin
          hbuf[hid_addr] <= hidden;
          if (hid_addr != HID_LAST) begin
            hid_addr <= hid_addr + 1'b1;
            pix_addr <= '0;
            state    <= S_H_TERM;
          end else begin
            hid_addr      <= '0;
            state         <= S_C_TERM;
            enable_hidden <= 1'b0;
            enable_classi <= 1'b1;
          end
        end
        S_C_TERM: begin
          if (hid_addr == HID_LAST) state <= S_C_BIAS;
          else hid_addr <= hid_addr + 1'b1;
        end
        S_C_BIAS: state <= S_C_SAMPLE;
        S_C_SAMPLE: begin
          if (cls_addr != CLS_LAST) begin
            cls_addr <= cls_addr + 1'b1;
            hid_addr <= '0;
            state    <= S_C_TERM;
          end else begin
            iter_left     <= iter_left - 1'b1;
            enable_classi <= 1'b0;
            pix_addr      <= '0;
            hid_addr      <= '0;
            cls_addr      <= '0;
            if (iter_left != 8'd1) begin
              state         <= S_H_TERM;
              enable_hidden <= 1'b1;
            end else begin
              state <= S_ARGMAX;
            end
          end
        end
        S_ARGMAX: begin
          if (cls_addr == CLS_LAST) state <= S_DONE;
          else cls_addr <= cls_addr + 1'b1;
        end
        S_DONE: begin
          done         <= 1'b1;
          busy         <= 1'b0;
          result_class <= best_idx;
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Memory data is same-cycle, so the operand muxes stay combinational on the registered state.
  always_comb begin
    hvalue       = '0;
    pixel        = 1'b0;
    cvalue       = '0;
    hidden_pixel = 1'b0;
    case (state)
      S_H_TERM: begin
        pixel  = image_bit;
        hvalue = h_weight;
      end
      S_H_BIAS, S_H_SAMPLE: begin
        pixel  = 1'b1;
        hvalue = h_bias;
      end
      S_C_TERM: begin
        hidden_pixel = hbuf[hid_addr];
        cvalue       = c_weight;
      end
      S_C_BIAS, S_C_SAMPLE: begin
        hidden_pixel = 1'b1;
        cvalue       = c_bias;
      end
      default: ;
    endcase
  end

  assign hidden_switch = order_bit;

endmodule

// File: tb/tb_rbm_sequencer.sv
// Self-checking bench for rbm_sequencer at small sizes with a behavioural Main and memory model.
module tb_rbm_sequencer;
  import rbm_pkg::*;

  localparam int NV  = 4;
  localparam int NH  = 3;
  localparam int NC  = 2;
  localparam int WW  = 12;
  localparam int CW  = 2;
  localparam int PW  = 2;
  localparam int HW  = 2;
  localparam int CLW = 1;
  localparam int EN_H_PER_ITER = NH * (NV + 2);
  localparam int EN_C_PER_ITER = NC * (NH + 2);

  logic          clock, reset, start;
  logic [7:0]    iterations;
  logic          busy, done;
  logic [CLW-1:0] result_class, cls_addr, cnt_sel;
  logic [PW-1:0] pix_addr;
  logic [HW-1:0] hid_addr;
  logic          image_bit, order_bit, hidden, spike;
  logic [WW-1:0] h_weight, h_bias, c_weight, c_bias, hvalue, cvalue;
  logic          pixel, hidden_switch, enable_hidden, hidden_pixel, enable_classi;
  logic [CW-1:0] cnt_out;
  logic [1:0]    spike_mode;

  int tests = 0;
  int fails = 0;

  rbm_sequencer #(
    .N_VISIBLE(NV), .N_HIDDEN(NH), .N_CLASS(NC), .W_WIDTH(WW), .CNT_W(CW)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .iterations(iterations),
    .busy(busy), .done(done), .result_class(result_class),
    .pix_addr(pix_addr), .hid_addr(hid_addr), .cls_addr(cls_addr),
    .image_bit(image_bit), .h_weight(h_weight), .h_bias(h_bias), .order_bit(order_bit),
    .c_weight(c_weight), .c_bias(c_bias),
    .hvalue(hvalue), .pixel(pixel), .hidden_switch(hidden_switch), .enable_hidden(enable_hidden),
    .cvalue(cvalue), .hidden_pixel(hidden_pixel), .enable_classi(enable_classi),
    .hidden(hidden), .spike(spike), .cnt_sel(cnt_sel), .cnt_out(cnt_out)
  );

  // Asynchronous memories and behavioural Main
  assign image_bit = pix_addr[0];
  assign h_weight  = {8'hA0, pix_addr, hid_addr};
  assign h_bias    = {8'hB0, 2'b00, hid_addr};
  assign order_bit = hid_addr[1];
  assign c_weight  = {8'hC0, 1'b0, hid_addr, cls_addr};
  assign c_bias    = {11'h0D0, cls_addr};
  assign hidden    = (hid_addr != 2'd1);

  always_comb begin
    case (spike_mode)
      2'd0:    spike = 1'b0;
      2'd1:    spike = (cls_addr == 1'b1);
      2'd2:    spike = (cls_addr == 1'b0);
      default: spike = 1'b1;
    endcase
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    int iters;
    int mode;
    int exp_latency;
    int exp_result;
    int exp_cnt0;
    int exp_cnt1;
    bit chk_cnt;
  } vec_t;

  vec_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {26'd0, busy, done, enable_hidden, enable_classi, pixel, hidden_pixel}, 32'd0);
    check({tag, "_addr"}, {26'd0, pix_addr, hid_addr, cls_addr, result_class}, 32'd0);
    check({tag, "_vals"}, {8'd0, hvalue, cvalue}, 32'd0);
  endtask

  // Cycle-exact checks of the first iteration at k cycles after start
  task automatic detail_check(input int k);
    if (k >= 1 && k <= 4) begin
      check($sformatf("pix_addr_c%0d", k), 32'(pix_addr), 32'(k - 1));
      check($sformatf("pixel_c%0d", k), 32'(pixel), 32'((k - 1) % 2));
      check($sformatf("hvalue_c%0d", k), 32'(hvalue), 32'(12'hA00 + (k - 1) * 4));
      check($sformatf("en_h_c%0d", k), {enable_hidden, enable_classi}, 32'b10);
    end
    if (k == 5) begin
      check("h_bias_pixel", 32'(pixel), 32'd1);
      check("h_bias_value", 32'(hvalue), 32'hB00);
    end
    if (k >= 19 && k <= 21) begin
      check($sformatf("hid_pixel_c%0d", k), 32'(hidden_pixel), (k - 19 != 1) ? 32'd1 : 32'd0);
      check($sformatf("cvalue_c%0d", k), 32'(cvalue), 32'(12'hC00 + (k - 19) * 2));
      check($sformatf("en_c_c%0d", k), {enable_hidden, enable_classi}, 32'b01);
    end
    if (k == 22) check("c_bias0", {19'd0, hidden_pixel, cvalue}, 32'h11A0);
    if (k == 27) check("c_bias1", {19'd0, hidden_pixel, cvalue}, 32'h11A1);
    if (k == 29 || k == 30) check($sformatf("argmax_en_c%0d", k), {enable_hidden, enable_classi}, 32'b00);
    if (k == 31) check("busy_before_done", {busy, done}, 32'b10);
  endtask

  task automatic run_vec(input vec_t v, input bit detail);
    int en_h = 0, en_c = 0, lat = 0;
    bit both = 0, sw_bad = 0, got = 0, busy_seen = 0;
    vec_t e;
    @(negedge clock);
    iterations = 8'(v.iters);
    spike_mode = 2'(v.mode);
    start      = 1'b1;
    exp_q.push_back(v);
    for (int k = 1; k <= 400; k++) begin
      @(negedge clock);
      start = 1'b0;
      if (k == 1) busy_seen = busy;
      if (enable_hidden) en_h++;
      if (enable_classi) en_c++;
      if (enable_hidden && enable_classi) both = 1'b1;
      if (hidden_switch !== order_bit) sw_bad = 1'b1;
      if (detail) detail_check(k);
      if (done) begin
        got = 1'b1;
        lat = k;
        break;
      end
    end
    e = exp_q.pop_front();
    if (!got) check($sformatf("done_timeout_it%0d", e.iters), 32'd0, 32'd1);
    check($sformatf("latency_it%0d", e.iters), 32'(lat), 32'(e.exp_latency));
    check($sformatf("busy_after_start_it%0d", e.iters), 32'(busy_seen), 32'd1);
    check($sformatf("busy_at_done_it%0d", e.iters), 32'(busy), 32'd0);
    check($sformatf("result_it%0d_m%0d", e.iters, e.mode), 32'(result_class), 32'(e.exp_result));
    check($sformatf("en_h_cycles_it%0d", e.iters), 32'(en_h), 32'(e.iters * EN_H_PER_ITER));
    check($sformatf("en_c_cycles_it%0d", e.iters), 32'(en_c), 32'(e.iters * EN_C_PER_ITER));
    check("enables_exclusive", 32'(both), 32'd0);
    check("hidden_switch", 32'(sw_bad), 32'd0);
    if (e.chk_cnt) begin
      cnt_sel = 1'b0;
      #1 check($sformatf("cnt0_it%0d_m%0d", e.iters, e.mode), 32'(cnt_out), 32'(e.exp_cnt0));
      cnt_sel = 1'b1;
      #1 check($sformatf("cnt1_it%0d_m%0d", e.iters, e.mode), 32'(cnt_out), 32'(e.exp_cnt1));
    end
  endtask

  initial begin
    vec_t vecs[10];
    bit stray_done;
    bit got;
    int lat;

    //        iters mode lat  res c0 c1 chk
    vecs[0] = '{1, 1,  32, 1, 0, 1, 1};
    vecs[1] = '{0, 1,   2, 0, 0, 0, 0};
    vecs[2] = '{3, 1,  88, 1, 0, 3, 1};
    vecs[3] = '{2, 2,  60, 0, 2, 0, 1};
    vecs[4] = '{2, 1,  60, 1, 0, 2, 1};
    vecs[5] = '{2, 3,  60, 0, 2, 2, 1};
    vecs[6] = '{5, 3, 144, 0, 3, 3, 1};
    vecs[7] = '{5, 1, 144, 1, 0, 3, 1};
    vecs[8] = '{4, 0, 116, 0, 0, 0, 1};
    vecs[9] = '{1, 1,  32, 1, 0, 1, 1};

    reset = 1'b1; start = 1'b0; iterations = 8'd0; spike_mode = 2'd0; cnt_sel = 1'b0;
    repeat (3) @(negedge clock);
    check_all_zero("reset");
    check("reset_cnt0", 32'(cnt_out), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i == 0);

    // Reset in C_TERM aborts the run; result_class is 1 beforehand so its clearing is visible
    @(negedge clock);
    iterations = 8'd1; spike_mode = 2'd1; start = 1'b1;
    got = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      start = 1'b0;
      if (enable_classi) begin
        got = 1'b1;
        break;
      end
    end
    check("reach_c_term", 32'(got), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_all_zero("mid_reset");
    stray_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (done || busy) stray_done = 1'b1;
    end
    check("no_done_after_reset", 32'(stray_done), 32'd0);

    // Start pulse during busy must not restart the run
    @(negedge clock);
    iterations = 8'd1; spike_mode = 2'd1; start = 1'b1;
    got = 1'b0; lat = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clock);
      start = 1'b0;
      if (k == 5) begin
        iterations = 8'd0;
        start = 1'b1;
      end
      if (done) begin
        got = 1'b1;
        lat = k;
        break;
      end
    end
    check("ignored_start_done", 32'(got), 32'd1);
    check("ignored_start_latency", 32'(lat), 32'd32);
    check("ignored_start_result", 32'(result_class), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
